// File: rtl/fetch_queue_pkg.sv
// Shared widths, entry layout and occupancy states for the fetch queue.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif

package fetch_queue_pkg;
    localparam int WORD_W       = `WORD;
    localparam int INSTR_W      = `INSTR_LEN;
    localparam int FQ_DEPTH_DEF = `FQ_DEPTH;

    typedef enum logic [1:0] {
        FQ_EMPTY,
        FQ_PARTIAL,
        FQ_FULL
    } fq_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WORD_W-1:0]  pc;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: synchronous write, asynchronous read, no reset.
module fq_ram #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flush drops all wrong-path entries.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [`INSTR_LEN-1:0] in_instr,
    input  logic [`WORD-1:0]      in_pc,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [`INSTR_LEN-1:0] out_instr,
    output logic [`WORD-1:0]      out_pc,
    input  logic                  out_ready,
    output logic [PTR_W:0]        count
);
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fq_state_e        state;
    logic             push, pop;
    fq_entry_t        wr_entry, rd_entry;

    always_comb begin
        state = FQ_PARTIAL;
        if (count_q == '0)
            state = FQ_EMPTY;
        else if (count_q == (PTR_W+1)'(DEPTH))
            state = FQ_FULL;
    end

    // in_ready ignores out_ready: a full queue refuses a push even while popping
    assign in_ready  = (state != FQ_FULL);
    assign out_valid = (state != FQ_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry.instr = in_instr;
    assign wr_entry.pc    = in_pc;

    fq_ram #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W ($bits(fq_entry_t))
    ) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign out_instr = out_valid ? rd_entry.instr : '0;
    assign out_pc    = out_valid ? rd_entry.pc    : '0;
    assign count     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random vs queue model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        ordy;
        int          e_cnt;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_ir;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] ins_of(input logic [63:0] pc);
        return 32'h1300_0000 | pc[31:0];
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] instr,
                                input logic [63:0] pc, input logic ordy, input int e_cnt,
                                input logic e_ov, input logic [31:0] e_instr,
                                input logic [63:0] e_pc, input logic e_ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [63:0] pc, input logic ordy);
        flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int e_cnt, input logic e_ov,
                             input logic [31:0] e_instr, input logic [63:0] e_pc, input logic e_ir);
        chk({tag, ".count"},     64'(count),     64'(e_cnt));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(e_instr));
        chk({tag, ".out_pc"},    out_pc,         e_pc);
        chk({tag, ".in_ready"},  64'(in_ready),  64'(e_ir));
    endtask

    // Asynchronous reset pulse placed strictly between clock edges
    task automatic mid_cycle_reset(input string tag);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1 reset = 1'b1;
        #1 chk_state(tag, 0, 1'b0, 32'h0, 64'h0, 1'b1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [95:0] model_q [$];
    logic [63:0] prev_pc;
    logic [63:0] rpc;

    initial begin
        vecs[0]  = mk(0, 1, 32'h8B020020, 64'h0,  0, 1, 1, 32'h8B020020, 64'h0, 1);
        vecs[1]  = mk(0, 0, 32'h0, 64'h0,         1, 0, 0, 32'h0, 64'h0, 1);
        vecs[2]  = mk(0, 1, ins_of(0),  64'd0,    0, 1, 1, ins_of(0), 64'd0, 1);
        vecs[3]  = mk(0, 1, ins_of(4),  64'd4,    0, 2, 1, ins_of(0), 64'd0, 1);
        vecs[4]  = mk(0, 1, ins_of(8),  64'd8,    0, 3, 1, ins_of(0), 64'd0, 1);
        vecs[5]  = mk(0, 1, ins_of(12), 64'd12,   0, 4, 1, ins_of(0), 64'd0, 0);
        vecs[6]  = mk(0, 1, ins_of(16), 64'd16,   0, 4, 1, ins_of(0), 64'd0, 0);
        vecs[7]  = mk(0, 1, ins_of(16), 64'd16,   1, 3, 1, ins_of(4), 64'd4, 1);
        vecs[8]  = mk(0, 1, ins_of(16), 64'd16,   0, 4, 1, ins_of(4), 64'd4, 0);
        vecs[9]  = mk(0, 0, 32'h0, 64'h0,         1, 3, 1, ins_of(8), 64'd8, 1);
        vecs[10] = mk(1, 1, ins_of(20), 64'd20,   1, 0, 0, 32'h0, 64'h0, 1);
        vecs[11] = mk(0, 1, ins_of(256), 64'h100, 0, 1, 1, ins_of(256), 64'h100, 1);
        vecs[12] = mk(0, 0, 32'h0, 64'h0,         1, 0, 0, 32'h0, 64'h0, 1);
        vecs[13] = mk(0, 0, 32'h0, 64'h0,         1, 0, 0, 32'h0, 64'h0, 1);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        chk_state("reset", 0, 1'b0, 32'h0, 64'h0, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy);
            chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov,
                      vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_ir);
        end

        // Steady push+pop from count=2; pointers wrap several times
        step(0, 1, ins_of(64'h200), 64'h200, 0);
        step(0, 1, ins_of(64'h204), 64'h204, 0);
        chk_state("fill2", 2, 1'b1, ins_of(64'h200), 64'h200, 1'b1);
        prev_pc = 64'h200;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, ins_of(64'h208 + 64'(4 * i)), 64'h208 + 64'(4 * i), 1);
            chk($sformatf("pp%0d.count", i), 64'(count), 64'd2);
            chk($sformatf("pp%0d.out_pc", i), out_pc, prev_pc + 64'd4);
            chk($sformatf("pp%0d.out_instr", i), 64'(out_instr), 64'(ins_of(prev_pc + 64'd4)));
            prev_pc = prev_pc + 64'd4;
        end

        mid_cycle_reset("midrst");
        step(0, 1, ins_of(64'h300), 64'h300, 0);
        chk_state("post_rst", 1, 1'b1, ins_of(64'h300), 64'h300, 1'b1);

        mid_cycle_reset("rst2");
        model_q.delete();
        rpc = 64'h1000;
        for (int i = 0; i < 300; i++) begin
            logic        fl, iv, ordy, do_push, do_pop;
            logic [31:0] ins;
            fl   = ($urandom % 16) == 0;
            iv   = $urandom_range(0, 1) == 1;
            ordy = ($urandom % 3) != 0;
            ins  = $urandom;
            do_push = iv && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() > 0);
            step(fl, iv, ins, rpc, ordy);
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back({ins, rpc});
            end
            if (do_push) rpc = rpc + 64'd4;
            if (model_q.size() == 0)
                chk_state($sformatf("rnd%0d", i), 0, 1'b0, 32'h0, 64'h0, 1'b1);
            else
                chk_state($sformatf("rnd%0d", i), model_q.size(), 1'b1,
                          model_q[0][95:64], model_q[0][63:0], model_q.size() < DEPTH);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Accepts fetched instruction/PC pairs through a valid/ready push port and presents them in order to decode through a valid/ready pop port.
- Decouples decode stalls from fetch.
- A branch-taken flush (the fetch stage's pc_src) discards all buffered, wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries and any same-cycle push (branch taken)
- in_valid  input  1  fetch presents an entry
- in_instr  input  `INSTR_LEN  fetched instruction
- in_pc  input  `WORD  address of in_instr
- in_ready  output  1  queue can accept an entry
- out_valid  output  1  head entry valid
- out_instr  output  `INSTR_LEN  head instruction
- out_pc  output  `WORD  head PC
- out_ready  input  1  decode consumes the head
- count  output  PTR_W+1  occupied entries, 0..DEPTH

Behaviour:
- Reset (asynchronous, active-high):
  - read pointer, write pointer and count go to 0.
  - out_valid=0, out_instr=0, out_pc=0, in_ready=1.
  - Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so a full queue refuses a push even in a pop cycle.
- out_valid = (count != 0).
- out_instr/out_pc:
  - Driven combinationally from the entry at the read pointer.
  - Forced to 0 when out_valid=0.
- Latency:
  - An entry pushed at edge N is visible on out_* after edge N (earliest pop at edge N+1).
  - There is no same-cycle bypass from empty.
- Push: write in_instr/in_pc at the write pointer; write pointer increments and wraps modulo DEPTH.
- Pop: read pointer increments and wraps modulo DEPTH.
- Count update:
  - push & !pop: +1
  - pop & !push: -1
  - push & pop: unchanged; both pointers advance.
- flush (synchronous, highest priority):
  - At the edge, count goes to 0 and read pointer = write pointer = 0.
  - A push or pop in the same cycle has no effect.
  - out_valid=0 from the following cycle.
  - in_ready stays as computed from count; flush does not gate it.
- Empty: out_ready with out_valid=0 has no effect.
- Full: in_valid with in_ready=0 is ignored; fetch must hold its entry.
- Handshake rules:
  - Fetch must hold in_* stable while in_valid & !in_ready.
  - Decode may drop out_ready at any time.
  - The head does not change unless a pop or flush occurs.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- Control states:
  - EMPTY (count=0), PARTIAL, FULL (count=DEPTH), all derived from count.
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at count=DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at count=1.
  - Any state→EMPTY on flush.

Decomposition:
- `WORD and `INSTR_LEN come from definitions.vh.
- Add `FQ_DEPTH (default 4) to definitions.vh for top-level instantiation.
- One sub-module: fq_ram.
  - DEPTH x (`INSTR_LEN+`WORD) register array.
  - Synchronous write port, asynchronous read port.
  - No reset.
- Pointer/count logic and output muxing stay in fetch_queue.

Test Plan:
- Reset, then push instr 32'h8B020020 / pc 64'h0 at edge 1 -> count=1 and out_valid=1 after edge 1; out_instr=32'h8B020020, out_pc=0; in_ready=1 throughout.
- Push pc 0,4,8,12 with out_ready=0 -> count=4 and in_ready=0; a 5th push (pc 16) with in_valid held is ignored; a single pop then returns pc 0, and pc 16 is accepted next cycle.
- Concurrent push and pop every cycle for 10 cycles from count=2 -> count stays 2; out_pc sequence is strictly increasing by 4; pointers wrap past DEPTH with no loss.
- Count=3 plus push and flush in the same cycle -> count=0 and out_valid=0 next cycle; a push of pc 64'h100 afterward appears as the head.
- Pop from empty (out_ready=1, in_valid=0) -> count stays 0; out_instr=0, out_pc=0.
- Assert reset between clock edges while count=2 -> count=0 and out_valid=0 immediately; after reset deasserts, the first push appears as the head.
